and_pulse_counter: RTL and testbench
====================================

# and_pulse_counter

Debounced event counter that sits directly downstream of the two-input AND stage. It takes the two AND operands, synchronises them into the local clock domain, and forms their AND. It accepts a level change only after the level has been stable for a programmable number of cycles. It emits a one-cycle pulse on every accepted rising edge and maintains a wrapping event count with a sticky overflow flag.

## Interface
- WIDTH, 8, width of the event counter (≥ 1)
- DEBOUNCE, 4, consecutive cycles a changed level must persist before acceptance (≥ 1)

- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  reset, asynchronous, active-high; one clock, reset is asynchronous and active-high
- a  input  1  AND operand, asynchronous to clk
- b  input  1  AND operand, asynchronous to clk
- clr  input  1  synchronous clear of count and ovf
- out_level  output  1  debounced AND level
- rise_pulse  output  1  one-cycle strobe per accepted rising edge
- count  output  WIDTH  accepted rising-edge count, wraps modulo 2^WIDTH
- ovf  output  1  sticky: set when count wraps from all-ones to 0

## Operation
- Synchronisers:
  - a and b each pass through a 2-flop synchroniser, reset to 0.
  - raw = a_s2 & b_s2.
- FSM states:
  - STABLE_LO: level 0, deb_cnt 0.
  - PEND_HI: raw 1, counting.
  - STABLE_HI: level 1.
  - PEND_LO: raw 0, counting.
- FSM transitions:
  - STABLE_LO→PEND_HI when raw=1. STABLE_HI→PEND_LO when raw=0. deb_cnt advances on these entry edges.
  - PEND_x back to its STABLE state when raw reverts. deb_cnt clears to 0 and no output changes.
- Acceptance:
  - At any edge where raw ≠ out_level and deb_cnt == DEBOUNCE-1, out_level takes raw, deb_cnt returns to 0, and the FSM enters the matching STABLE state.
  - Otherwise, while raw ≠ out_level, deb_cnt increments.
  - DEBOUNCE=1 accepts on the first edge that sees a changed raw.
- deb_cnt width is clog2(DEBOUNCE)+1 and never exceeds DEBOUNCE-1.
- Rising-edge acceptance:
  - rise_pulse=1 for exactly one cycle.
  - count increments by 1 on the same edge.
  - A falling acceptance produces no pulse and no count change.
- Wrap: count at 2^WIDTH-1 plus an accepted rise gives count=0 and ovf=1. ovf stays 1 until clr or rst.
- clr:
  - At an edge with clr=1, count=0 and ovf=0.
  - If an accepted rise coincides with clr, count=1 and ovf=0: the event is not lost, and rise_pulse still fires.
  - clr does not affect the FSM, out_level or the synchronisers.
- Reset (async, any time, including mid-debounce):
  - All flops go to 0 and the FSM enters STABLE_LO.
  - out_level=0, rise_pulse=0, count=0, ovf=0.
  - A pending count is discarded.
  - After release, a and b already high are treated as a new rise and must debounce fully.

## Timing
- Edge numbering: edge 0 is the first rising clk edge that samples a&b=1 into the first synchroniser stage.
- raw=1 after edge 1.
- Edges 2..DEBOUNCE+1 each observe raw ≠ out_level.
- out_level=1, rise_pulse=1 and count+1 all take effect after edge DEBOUNCE+1.
- Input-to-output latency is DEBOUNCE+2 edges; with the default DEBOUNCE=4, the change appears after edge 5.
- Falling edges have the same latency.
- rise_pulse is registered and deasserts after the next edge.
- Minimum accepted high pulse width: DEBOUNCE cycles of stable raw.
- Minimum spacing of two counted rises: 2·DEBOUNCE cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, DEBOUNCE=4: assert rst, then set a=b=1 with rst high → all outputs 0. Release rst and hold a=b=1 → rise_pulse once 6 edges after the first sampling edge, count=1, out_level=1.
- Glitch rejection: a=1 held; b high for 3 cycles then low → out_level, rise_pulse and count unchanged. Repeat with a 4-cycle b pulse → count increments by 1.
- Operand masking: a toggles with b=0 for 50 cycles → count=0, out_level=0.
- Wrap, WIDTH=3: 8 clean rises → count sequence 1..7 then 0, ovf=1 after the 8th. A 9th rise gives count=1, ovf=1. Pulse clr → count=0, ovf=0.
- Clear collision: preload count=5; assert clr on the same edge as an accepted rise → count=1, ovf=0, rise_pulse=1.
- Reset mid-debounce: a=b=1 held; assert rst asynchronously 3 edges after sampling → outputs 0 immediately. Release with inputs still high → full DEBOUNCE+2-edge latency before the pulse, count=1.

Source files
------------

// File: rtl/and_pulse_counter.sv
// rtl/and_pulse_counter.sv - debounced AND-level edge counter with sticky wrap flag
// Synchronises two operands, debounces their AND, pulses and counts accepted rises.
module and_pulse_counter #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             out_level,
  output logic             rise_pulse,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] deb_cnt;
  logic          a_s1, a_s2, b_s1, b_s2;
  logic          raw;
  logic          accept_rise;
  logic          accept_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
    end else begin
      a_s1 <= a;
      a_s2 <= a_s1;
      b_s1 <= b;
      b_s2 <= b_s1;
    end
  end

  always_comb begin
    raw         = a_s2 & b_s2;
    accept_rise = raw && !out_level && (deb_cnt == DEB_LAST);
    accept_fall = !raw && out_level && (deb_cnt == DEB_LAST);
  end

  // deb_cnt counts edges that have seen raw differ from the accepted level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= STABLE_LO;
      deb_cnt    <= '0;
      out_level  <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      rise_pulse <= accept_rise;
      if (accept_rise) begin
        state     <= STABLE_HI;
        deb_cnt   <= '0;
        out_level <= 1'b1;
      end else if (accept_fall) begin
        state     <= STABLE_LO;
        deb_cnt   <= '0;
        out_level <= 1'b0;
      end else begin
        case (state)
          STABLE_LO: begin
            if (raw) begin
              state   <= PEND_HI;
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
          PEND_HI: begin
            if (raw) begin
              deb_cnt <= deb_cnt + 1'b1;
            end else begin
              state   <= STABLE_LO;
              deb_cnt <= '0;
            end
          end
          STABLE_HI: begin
            if (!raw) begin
              state   <= PEND_LO;
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
          PEND_LO: begin
            if (!raw) begin
              deb_cnt <= deb_cnt + 1'b1;
            end else begin
              state   <= STABLE_HI;
              deb_cnt <= '0;
            end
          end
          default: begin
            state   <= STABLE_LO;
            deb_cnt <= '0;
          end
        endcase
      end
    end
  end

  // A rise coinciding with clr still counts, so the event survives the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= accept_rise ? WIDTH'(1) : '0;
      ovf   <= 1'b0;
    end else if (accept_rise) begin
      count <= count + 1'b1;
      if (&count) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_and_pulse_counter.sv
// tb/tb_and_pulse_counter.sv - directed checks of and_pulse_counter
// Main instance uses WIDTH=3, DEBOUNCE=4; a DEBOUNCE=1 instance shares the inputs.
module tb_and_pulse_counter;

  logic       clk = 1'b0;
  logic       rst, a, b, clr;
  logic       out_level, rise_pulse, ovf;
  logic [2:0] count;
  logic       out_level1, rise_pulse1, ovf1;
  logic [7:0] count1;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic exp_ovf = 1'b0;

  always #5 clk = ~clk;

  and_pulse_counter #(.WIDTH(3), .DEBOUNCE(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
    .out_level(out_level), .rise_pulse(rise_pulse), .count(count), .ovf(ovf)
  );

  and_pulse_counter #(.WIDTH(8), .DEBOUNCE(1)) dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
    .out_level(out_level1), .rise_pulse(rise_pulse1), .count(count1), .ovf(ovf1)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Clean rise: accepted after edge 5, then a clean fall back to low.
  task automatic do_rise(input string tag);
    a = 1'b1;
    b = 1'b1;
    tick(5);
    check({tag, "_pre_pulse"}, {31'd0, rise_pulse}, 32'd0);
    tick(1);
    exp_count = (exp_count + 1) % 8;
    if (exp_count == 0) exp_ovf = 1'b1;
    check({tag, "_pulse"}, {31'd0, rise_pulse}, 32'd1);
    check({tag, "_count"}, {29'd0, count}, exp_count);
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    b = 1'b0;
    tick(8);
  endtask

  initial begin
    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    clr = 1'b0;
    tick(2);
    a = 1'b1;
    b = 1'b1;
    tick(3);
    check("rst_level", {31'd0, out_level}, 32'd0);
    check("rst_pulse", {31'd0, rise_pulse}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);

    // release; the next posedge is edge 0
    rst = 1'b0;
    tick(2);
    check("d1_edge1_level", {31'd0, out_level1}, 32'd0);
    tick(1);
    check("d1_edge2_level", {31'd0, out_level1}, 32'd1);
    check("d1_edge2_pulse", {31'd0, rise_pulse1}, 32'd1);
    check("d1_edge2_count", {24'd0, count1}, 32'd1);
    tick(2);
    check("lat_edge4_pulse", {31'd0, rise_pulse}, 32'd0);
    check("lat_edge4_level", {31'd0, out_level}, 32'd0);
    tick(1);
    check("lat_edge5_pulse", {31'd0, rise_pulse}, 32'd1);
    check("lat_edge5_level", {31'd0, out_level}, 32'd1);
    check("lat_edge5_count", {29'd0, count}, 32'd1);
    tick(1);
    check("lat_edge6_pulse", {31'd0, rise_pulse}, 32'd0);
    exp_count = 1;

    // fall with equal latency
    b = 1'b0;
    tick(5);
    check("fall_edge4_level", {31'd0, out_level}, 32'd1);
    tick(1);
    check("fall_edge5_level", {31'd0, out_level}, 32'd0);
    check("fall_no_pulse", {31'd0, rise_pulse}, 32'd0);
    check("fall_count", {29'd0, count}, 32'd1);
    tick(3);

    // 3-cycle glitch on b is rejected
    b = 1'b1;
    tick(3);
    b = 1'b0;
    tick(10);
    check("glitch3_level", {31'd0, out_level}, 32'd0);
    check("glitch3_count", {29'd0, count}, 32'd1);

    // 4-cycle pulse is accepted
    b = 1'b1;
    tick(4);
    b = 1'b0;
    tick(2);
    check("pulse4_pulse", {31'd0, rise_pulse}, 32'd1);
    check("pulse4_count", {29'd0, count}, 32'd2);
    exp_count = 2;
    tick(10);
    check("pulse4_fall_level", {31'd0, out_level}, 32'd0);

    // a toggling while b=0 is masked
    for (int i = 0; i < 50; i++) begin
      a = ~a;
      tick(1);
    end
    tick(6);
    check("mask_level", {31'd0, out_level}, 32'd0);
    check("mask_count", {29'd0, count}, 32'd2);

    // rises up to wrap (count 3..7, 0) and one past it
    for (int i = 0; i < 7; i++) do_rise("wrap");
    check("wrap_sticky_ovf", {31'd0, ovf}, 32'd1);
    // preload to 5 with ovf still set
    for (int i = 0; i < 4; i++) do_rise("preload");

    // clr coinciding with accepted rise
    a = 1'b1;
    b = 1'b1;
    tick(5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("coll_count", {29'd0, count}, 32'd1);
    check("coll_ovf", {31'd0, ovf}, 32'd0);
    check("coll_pulse", {31'd0, rise_pulse}, 32'd1);
    check("coll_level", {31'd0, out_level}, 32'd1);

    // plain clr pulse leaves level alone
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_count", {29'd0, count}, 32'd0);
    check("clr_level", {31'd0, out_level}, 32'd1);
    b = 1'b0;
    tick(8);
    exp_count = 0;
    exp_ovf = 1'b0;
    do_rise("post_clr");

    // reset mid-debounce
    a = 1'b1;
    b = 1'b1;
    tick(4);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_count", {29'd0, count}, 32'd0);
    check("mid_rst_level", {31'd0, out_level}, 32'd0);
    check("mid_rst_pulse", {31'd0, rise_pulse}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(5);
    check("rel_edge4_pulse", {31'd0, rise_pulse}, 32'd0);
    tick(1);
    check("rel_edge5_pulse", {31'd0, rise_pulse}, 32'd1);
    check("rel_edge5_count", {29'd0, count}, 32'd1);
    check("rel_edge5_ovf", {31'd0, ovf}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
